mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter between the core's instruction-fetch path and its data-access (load/store) path. It replaces the ad-hoc fetch/data address mux in the core. Each cycle it grants at most one requester, drives the RAM address, write data and write enable, and routes the RAM read word back to the owner one cycle later. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
- `RAM_AW`, default 30: RAM word-address width; the RAM address is byte address bits [RAM_AW+1:2].
- `STARVE_MAX`, default 4: consecutive denied fetch cycles after which fetch wins over data; legal range 1..15.
- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `if_req`, in, 1: fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`, in, 32: fetch byte address; bits [1:0] are ignored.
- `if_gnt`, out, 1: fetch granted this cycle (combinational).
- `if_rvalid`, out, 1: fetch word valid on `if_rdata`; a registered 1-cycle pulse.
- `if_rdata`, out, 32: fetch word; holds the last returned word.
- `d_req`, in, 1: data request; held with `d_we`, `d_addr` and `d_wdata` until `d_gnt`.
- `d_we`, in, 1: 1 = store, 0 = load.
- `d_addr`, in, 32: data byte address; must be word-aligned.
- `d_wdata`, in, 32: store data.
- `d_gnt`, out, 1: data request granted this cycle (combinational).
- `d_done`, out, 1: data access completed; a registered 1-cycle pulse.
- `d_err`, out, 1: qualifies `d_done`; the access was misaligned and was not performed.
- `d_rdata`, out, 32: load word; holds the last returned load word.
- `ram_address`, out, RAM_AW: RAM word address.
- `ram_data`, out, 32: RAM write data.
- `ram_wren`, out, 1: RAM write enable.
- `ram_q`, in, 32: RAM read data, valid the cycle after the address is presented.

## Operation
**Arbitration.** Each cycle:
- If `d_req` is high and `starve_cnt` < STARVE_MAX, data wins.
- Otherwise, if `if_req` is high, fetch wins.
- Otherwise no grant is issued.
- At most one of `if_gnt`/`d_gnt` is high in any cycle.

**Starvation counter.**
- `starve_cnt` increments on each cycle with `if_req` high and `if_gnt` low.
- It clears on `if_gnt` or on `if_req` low.
- It saturates at STARVE_MAX.

**Pending-owner register.** `pend` has the states NONE, IF, DRD, DWR, DERR.
- It is loaded every cycle from that cycle's grant: IF for a fetch, DRD for a load, DWR for a store, DERR for a misaligned data access, NONE when nothing is granted.
- There are no stall states; a grant may be issued every cycle.

**Grant cycle.**
- `ram_address` is taken from the winner's address bits [RAM_AW+1:2].
- With no grant, `ram_address` holds the fetch address.
- `ram_wren` = `d_gnt` & `d_we` & aligned.
- `ram_data` = `d_wdata`.

**Misaligned data access** (`d_addr[1:0]` ≠ 0):
- `d_gnt` is still asserted and `ram_wren` stays 0.
- The next cycle gives `d_done`=1 and `d_err`=1.
- `d_rdata` is unchanged.

**Return cycle, by the value of `pend`:**
- IF: `if_rvalid`=1 and `if_rdata`=`ram_q`; the hold register captures `ram_q`.
- DRD: `d_done`=1, `d_err`=0, `d_rdata`=`ram_q`; the hold register captures `ram_q`.
- DWR: `d_done`=1, `d_err`=0; `d_rdata` is unchanged.
- When not valid, each rdata output shows its hold register.

**Reset.** Asynchronous, active-low.
- `pend`=NONE, `starve_cnt`=0, both hold registers = 0.
- Registered outputs are 0: `if_rvalid`, `d_done`, `d_err`, `if_rdata`, `d_rdata`.
- While `reset_n`=0, `if_gnt`, `d_gnt` and `ram_wren` are forced to 0.
- A reset in the cycle after a grant discards the pending return; no valid or done pulse is issued.

## Timing
- Grant-to-data latency is exactly 1 cycle: the grant occurs in cycle N, and `if_rvalid`/`d_done` are asserted in N+1.
- Throughput is one access per cycle. Back-to-back grants to alternating owners are legal; each return is tagged by `pend`.
- A store's RAM write takes effect at the clk edge ending the grant cycle.
- A load granted in cycle N+1 to the same word as a store granted in N returns the new data.
- The requester may drop or change its request in the cycle after its grant.
- A requester must not change its request fields while its request is high and its grant is low.
- When both requesters are high continuously, fetch is granted once every STARVE_MAX+1 cycles.

## Structure
- Package `kanade_mem_pkg` holds:
  - the `pend_t` enum (NONE, IF, DRD, DWR, DERR);
  - `WORD_BYTES`=4;
  - the default `RAM_AW`.
- Single module; no sub-module is warranted. The arbiter/starvation logic is combinational.
- Registers: `pend`, `starve_cnt`, and the two hold registers.
- The RAM model used by the bench is the existing synchronous-read RAM.

## Test plan
- **Fetch only, consecutive addresses:** `if_req`=1 with `if_addr` 0x0, 0x4, 0x8 on successive grants; RAM preloaded with 0x11, 0x22, 0x33 → `if_gnt` high every cycle, and `if_rvalid`/`if_rdata` give 0x11, 0x22, 0x33 one cycle later.
- **Store then load:** store 0xDEADBEEF to 0x40, then load 0x40 granted the next cycle → store `d_done`, `d_err`=0, then `d_rdata`=0xDEADBEEF with `d_done`.
- **Contention, STARVE_MAX=4:** `if_req` and `d_req` held high for 10 cycles → data granted in cycles 0–3, fetch in cycle 4, data in 5–8, fetch in 9; never both grants high.
- **Misaligned access:** store to 0x42 → `d_gnt`=1, `ram_wren`=0, the next cycle `d_done`=1 and `d_err`=1; RAM word 0x40 is unchanged.
- **Reset mid-operation:** assert `reset_n`=0 in the cycle after a fetch grant → `if_rvalid` stays 0; after release all outputs are 0 and the next fetch returns correctly.

Source files
------------

// File: rtl/kanade_mem_pkg.sv
// Shared types and constants for the core's RAM arbitration path.
package kanade_mem_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned RAM_AW_DEFAULT = 30;
  localparam int unsigned STARVE_W       = 4;

  // Owner of the RAM read word arriving in the following cycle
  typedef enum logic [2:0] {
    NONE,
    IF,
    DRD,
    DWR,
    DERR
  } pend_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data has priority; a starvation counter guarantees fetch progress.
module mem_arbiter
  import kanade_mem_pkg::*;
#(
  parameter int unsigned RAM_AW     = RAM_AW_DEFAULT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic [RAM_AW-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned         LSB        = $clog2(WORD_BYTES);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  pend_t               pend_q, pend_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   if_hold_q, if_hold_d;
  logic [DATA_W-1:0]   d_hold_q, d_hold_d;
  logic                d_aligned;
  logic                unused_addr_bits;

  assign d_aligned        = (d_addr[LSB-1:0] == '0);
  assign unused_addr_bits = ^{if_addr, d_addr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q    <= NONE;
      starve_q  <= '0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      pend_q    <= pend_d;
      starve_q  <= starve_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

  // Grant, RAM drive and next owner for the current cycle
  always_comb begin
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    pend_d      = NONE;
    starve_d    = '0;
    ram_address = if_addr[RAM_AW+LSB-1:LSB];
    ram_data    = d_wdata;
    ram_wren    = 1'b0;

    if (reset_n) begin
      if (d_req && (starve_q < STARVE_LIM)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end

    if (if_req && !if_gnt) begin
      starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + STARVE_W'(1);
    end

    if (if_gnt) begin
      pend_d = IF;
    end else if (d_gnt) begin
      ram_address = d_addr[RAM_AW+LSB-1:LSB];
      ram_wren    = d_we && d_aligned;
      if (!d_aligned) begin
        pend_d = DERR;
      end else if (d_we) begin
        pend_d = DWR;
      end else begin
        pend_d = DRD;
      end
    end
  end

  // Return cycle: route the RAM word to whoever was granted last cycle
  always_comb begin
    if_rvalid = (pend_q == IF);
    d_done    = (pend_q == DRD) || (pend_q == DWR) || (pend_q == DERR);
    d_err     = (pend_q == DERR);
    if_rdata  = (pend_q == IF) ? ram_q : if_hold_q;
    d_rdata   = (pend_q == DRD) ? ram_q : d_hold_q;
    if_hold_d = if_rdata;
    d_hold_d  = d_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  import kanade_mem_pkg::*;

  localparam int unsigned RAM_AW     = 30;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned DEPTH      = 256;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [31:0]       d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic              if_gnt, if_rvalid, d_gnt, d_done, d_err, ram_wren;
  logic [31:0]       if_rdata, d_rdata, ram_data;
  logic [RAM_AW-1:0] ram_address;
  logic [31:0]       ram_q;

  mem_arbiter #(.RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with a bench-side preload port
  logic [31:0] ram [DEPTH];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (ram_wren) ram[ram_address[7:0]] <= ram_data;
    ram_q <= ram[ram_address[7:0]];
  end

  // Reference model state
  typedef enum int {K_NONE, K_IF, K_DRD, K_DWR, K_DERR} kind_e;
  logic [31:0] exp_mem [DEPTH];
  int          m_starve;
  kind_e       m_kind;
  logic [31:0] m_data, m_if_hold, m_d_hold;
  bit          have_prev;

  bit          s_if_gnt, s_d_gnt, s_if_req, s_d_we;
  logic [31:0] s_if_addr, s_d_addr, s_d_wdata;

  bit                e_if_gnt, e_d_gnt, e_ram_wren, e_if_rvalid, e_d_done, e_d_err;
  logic [RAM_AW-1:0] e_ram_addr;
  logic [31:0]       e_if_rdata, e_d_rdata;

  int n_pass = 0;
  int n_total = 0;

  task automatic model_reset();
    m_starve  = 0;
    m_kind    = K_NONE;
    m_data    = '0;
    m_if_hold = '0;
    m_d_hold  = '0;
    have_prev = 1'b0;
  endtask

  // Retire last cycle's return, then book the access granted in the sampled cycle
  task automatic model_commit();
    if (m_kind == K_IF)  m_if_hold = m_data;
    if (m_kind == K_DRD) m_d_hold  = m_data;
    m_kind = K_NONE;
    if (s_if_gnt) begin
      m_kind = K_IF;
      m_data = exp_mem[s_if_addr[9:2]];
    end else if (s_d_gnt) begin
      if (s_d_addr[1:0] != 2'b00) begin
        m_kind = K_DERR;
      end else if (s_d_we) begin
        m_kind = K_DWR;
        exp_mem[s_d_addr[9:2]] = s_d_wdata;
      end else begin
        m_kind = K_DRD;
        m_data = exp_mem[s_d_addr[9:2]];
      end
    end
    if (s_if_req && !s_if_gnt) m_starve = (m_starve >= STARVE_MAX) ? STARVE_MAX : m_starve + 1;
    else m_starve = 0;
  endtask

  // Drive one cycle of requests and compute what the model expects to see in it
  task automatic apply(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    if (have_prev) model_commit();
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #1;
    e_d_gnt     = dr && (m_starve < STARVE_MAX);
    e_if_gnt    = !e_d_gnt && ir;
    e_ram_wren  = e_d_gnt && dw && (da[1:0] == 2'b00);
    e_ram_addr  = e_d_gnt ? RAM_AW'(da >> 2) : RAM_AW'(ia >> 2);
    e_if_rvalid = (m_kind == K_IF);
    e_if_rdata  = e_if_rvalid ? m_data : m_if_hold;
    e_d_done    = m_kind inside {K_DRD, K_DWR, K_DERR};
    e_d_err     = (m_kind == K_DERR);
    e_d_rdata   = (m_kind == K_DRD) ? m_data : m_d_hold;
    s_if_gnt = e_if_gnt; s_d_gnt = e_d_gnt; s_if_req = ir; s_d_we = dw;
    s_if_addr = ia; s_d_addr = da; s_d_wdata = dd;
    have_prev = 1'b1;
  endtask

  task automatic preload_ram();
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [31:0] v;
      v = (i < 3) ? 32'h11 * 32'(i + 1) : $urandom;
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 8'(i); pl_data = v;
      exp_mem[i] = v;
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5A5A5;
    @(negedge clk); #1;
    n_total++; if (if_gnt !== 1'b0) $display("FAIL reset if_gnt got %b want 0", if_gnt); else n_pass++;
    n_total++; if (d_gnt !== 1'b0) $display("FAIL reset d_gnt got %b want 0", d_gnt); else n_pass++;
    n_total++; if (ram_wren !== 1'b0) $display("FAIL reset ram_wren got %b want 0", ram_wren); else n_pass++;
    n_total++; if ({if_rvalid, d_done, d_err} !== 3'b000)
      $display("FAIL reset pulses got %b want 000", {if_rvalid, d_done, d_err}); else n_pass++;
    n_total++; if (if_rdata !== 32'h0) $display("FAIL reset if_rdata got %h want 0", if_rdata); else n_pass++;
    n_total++; if (d_rdata !== 32'h0) $display("FAIL reset d_rdata got %h want 0", d_rdata); else n_pass++;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch_seq();
    logic [31:0] want [3];
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33;
    for (int i = 0; i < 5; i++) begin
      apply(i < 3, 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0);
      if (i < 3) begin
        n_total++; if (if_gnt !== 1'b1) $display("FAIL fetch%0d if_gnt got %b want 1", i, if_gnt); else n_pass++;
      end
      if (i >= 1 && i <= 3) begin
        n_total++; if (if_rvalid !== 1'b1) $display("FAIL fetch%0d if_rvalid got %b want 1", i, if_rvalid); else n_pass++;
        n_total++; if (if_rdata !== want[i-1])
          $display("FAIL fetch%0d if_rdata got %h want %h", i, if_rdata, want[i-1]); else n_pass++;
      end
    end
    n_total++; if (if_rvalid !== 1'b0) $display("FAIL fetch_idle if_rvalid got %b want 0", if_rvalid); else n_pass++;
    n_total++; if (if_rdata !== 32'h33) $display("FAIL fetch_hold if_rdata got %h want 33", if_rdata); else n_pass++;
  endtask

  task automatic test_store_load();
    apply(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    n_total++; if (d_gnt !== 1'b1) $display("FAIL st d_gnt got %b want 1", d_gnt); else n_pass++;
    n_total++; if (ram_wren !== 1'b1) $display("FAIL st ram_wren got %b want 1", ram_wren); else n_pass++;
    n_total++; if (ram_address !== RAM_AW'(16)) $display("FAIL st ram_address got %h want 10", ram_address); else n_pass++;
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    n_total++; if ({d_done, d_err} !== 2'b10) $display("FAIL st_done done/err got %b want 10", {d_done, d_err}); else n_pass++;
    n_total++; if (d_gnt !== 1'b1) $display("FAIL ld d_gnt got %b want 1", d_gnt); else n_pass++;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_total++; if ({d_done, d_err} !== 2'b10) $display("FAIL ld_done done/err got %b want 10", {d_done, d_err}); else n_pass++;
    n_total++; if (d_rdata !== 32'hDEADBEEF) $display("FAIL ld d_rdata got %h want deadbeef", d_rdata); else n_pass++;
  endtask

  task automatic test_misaligned();
    apply(1'b0, 32'h0, 1'b1, 1'b1, 32'h42, 32'h12345678);
    n_total++; if (d_gnt !== 1'b1) $display("FAIL mis d_gnt got %b want 1", d_gnt); else n_pass++;
    n_total++; if (ram_wren !== 1'b0) $display("FAIL mis ram_wren got %b want 0", ram_wren); else n_pass++;
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    n_total++; if ({d_done, d_err} !== 2'b11) $display("FAIL mis_done done/err got %b want 11", {d_done, d_err}); else n_pass++;
    n_total++; if (d_rdata !== 32'hDEADBEEF) $display("FAIL mis d_rdata got %h want deadbeef", d_rdata); else n_pass++;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_total++; if (d_err !== 1'b0) $display("FAIL mis_ld d_err got %b want 0", d_err); else n_pass++;
    n_total++; if (d_rdata !== 32'hDEADBEEF) $display("FAIL mis_ld word0x40 got %h want deadbeef", d_rdata); else n_pass++;
  endtask

  task automatic test_contention();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      bit want_if;
      want_if = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
      apply(1'b1, 32'h80, 1'b1, 1'b0, 32'h44, 32'h0);
      n_total++; if (if_gnt !== want_if) $display("FAIL cont%0d if_gnt got %b want %b", i, if_gnt, want_if); else n_pass++;
      n_total++; if (d_gnt !== !want_if) $display("FAIL cont%0d d_gnt got %b want %b", i, d_gnt, !want_if); else n_pass++;
    end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random(input int cycles);
    bit ir = 1'b0, dr = 1'b0, dw = 1'b0, pig = 1'b0, pdg = 1'b0;
    logic [31:0] ia = '0, da = '0, dd = '0;
    for (int c = 0; c < cycles; c++) begin
      if (!ir || pig) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
      end
      if (!dr || pdg) begin
        dr = ($urandom_range(0, 1) != 0);
        dw = ($urandom_range(0, 1) != 0);
        da = {22'd0, 8'($urandom_range(0, 255)),
              ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
        dd = $urandom;
      end
      apply(ir, ia, dr, dw, da, dd);
      pig = e_if_gnt; pdg = e_d_gnt;
      n_total++; if (if_gnt !== e_if_gnt) $display("FAIL rnd%0d if_gnt got %b want %b", c, if_gnt, e_if_gnt); else n_pass++;
      n_total++; if (d_gnt !== e_d_gnt) $display("FAIL rnd%0d d_gnt got %b want %b", c, d_gnt, e_d_gnt); else n_pass++;
      n_total++; if (ram_wren !== e_ram_wren) $display("FAIL rnd%0d ram_wren got %b want %b", c, ram_wren, e_ram_wren); else n_pass++;
      n_total++; if (ram_address !== e_ram_addr)
        $display("FAIL rnd%0d ram_address got %h want %h", c, ram_address, e_ram_addr); else n_pass++;
      n_total++; if (if_rvalid !== e_if_rvalid) $display("FAIL rnd%0d if_rvalid got %b want %b", c, if_rvalid, e_if_rvalid); else n_pass++;
      n_total++; if (if_rdata !== e_if_rdata) $display("FAIL rnd%0d if_rdata got %h want %h", c, if_rdata, e_if_rdata); else n_pass++;
      n_total++; if ({d_done, d_err} !== {e_d_done, e_d_err})
        $display("FAIL rnd%0d done/err got %b want %b", c, {d_done, d_err}, {e_d_done, e_d_err}); else n_pass++;
      n_total++; if (d_rdata !== e_d_rdata) $display("FAIL rnd%0d d_rdata got %h want %h", c, d_rdata, e_d_rdata); else n_pass++;
      if (e_d_gnt && dw) begin
        n_total++; if (ram_data !== dd) $display("FAIL rnd%0d ram_data got %h want %h", c, ram_data, dd); else n_pass++;
      end
    end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    apply(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    n_total++; if (if_gnt !== 1'b1) $display("FAIL rstmid grant if_gnt got %b want 1", if_gnt); else n_pass++;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_total++; if (if_rvalid !== 1'b0) $display("FAIL rstmid if_rvalid got %b want 0", if_rvalid); else n_pass++;
    n_total++; if (if_gnt !== 1'b0) $display("FAIL rstmid if_gnt got %b want 0", if_gnt); else n_pass++;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    if_req = 1'b0;
    reset_n = 1'b1;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_total++; if ({if_rvalid, d_done, d_err} !== 3'b000)
      $display("FAIL rstmid_post pulses got %b want 000", {if_rvalid, d_done, d_err}); else n_pass++;
    n_total++; if ({if_rdata, d_rdata} !== 64'h0)
      $display("FAIL rstmid_post rdata got %h/%h want 0/0", if_rdata, d_rdata); else n_pass++;
    apply(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    n_total++; if (if_gnt !== 1'b1) $display("FAIL rstmid_refetch if_gnt got %b want 1", if_gnt); else n_pass++;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_total++; if (if_rvalid !== 1'b1) $display("FAIL rstmid_refetch if_rvalid got %b want 1", if_rvalid); else n_pass++;
    n_total++; if (if_rdata !== exp_mem[1])
      $display("FAIL rstmid_refetch if_rdata got %h want %h", if_rdata, exp_mem[1]); else n_pass++;
  endtask

  initial begin
    model_reset();
    preload_ram();
    test_reset();
    test_fetch_seq();
    test_store_load();
    test_misaligned();
    test_contention();
    test_random(400);
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
